// File: rtl/lfsr6_pkg.sv
// Shared types, thresholds and the feedback tap function for the x^6+x^5+1 PRBS checker.
// Pure declarations: no latency and no flow control.
package lfsr6_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_UNUSED = 2'd3
  } state_e;

  localparam int LOCK_CNT = 8;
  localparam int LOSS_CNT = 3;
  localparam int SEED_LEN = 6;
  localparam int ERR_W    = 8;

  function automatic logic lfsr6_fb(input logic [5:0] h);
    return h[5] ^ h[4];
  endfunction

endpackage

// File: rtl/lfsr6_prbs_checker.sv
// Serial PRBS6 checker: seeds from the line, verifies, then free-runs and counts bit errors.
// locked/err/err_cnt/state are registered, 1 cycle after the sampling edge; no backpressure, en gates everything.
module lfsr6_prbs_checker
  import lfsr6_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam logic [2:0] FILL_FULL = 3'(SEED_LEN);
  localparam logic [3:0] LOCK_FULL = 4'(LOCK_CNT);
  localparam logic [1:0] LOSS_FULL = 2'(LOSS_CNT);

  state_e           state_q, state_d;
  logic [5:0]       h_q, h_d;
  logic [2:0]       fill_cnt_q, fill_cnt_d;
  logic [3:0]       ok_cnt_q, ok_cnt_d;
  logic [1:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             exp_bit;
  logic [2:0]       fill_inc;
  logic [3:0]       ok_inc;
  logic [1:0]       miss_inc;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    fill_cnt_d = fill_cnt_q;
    ok_cnt_d   = ok_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    exp_bit    = lfsr6_fb(h_q);
    fill_inc   = fill_cnt_q + 3'd1;
    ok_inc     = ok_cnt_q + 4'd1;
    miss_inc   = miss_cnt_q + 2'd1;

    case (state_q)
      ST_SEARCH: begin
        if (en) begin
          h_d = {h_q[4:0], din};
          if (fill_inc == FILL_FULL) begin
            fill_cnt_d = 3'd0;
            ok_cnt_d   = 4'd0;
            // An all-zero seed is the LFSR lockup state and can never predict anything.
            if (h_d != 6'd0) begin
              state_d = ST_VERIFY;
            end
          end else begin
            fill_cnt_d = fill_inc;
          end
        end
      end

      ST_VERIFY: begin
        if (en) begin
          h_d = {h_q[4:0], din};
          if (din == exp_bit) begin
            if (ok_inc == LOCK_FULL) begin
              state_d    = ST_LOCKED;
              ok_cnt_d   = 4'd0;
              miss_cnt_d = 2'd0;
            end else begin
              ok_cnt_d = ok_inc;
            end
          end else begin
            state_d    = ST_SEARCH;
            fill_cnt_d = 3'd0;
            ok_cnt_d   = 4'd0;
          end
        end
      end

      ST_LOCKED: begin
        if (en) begin
          // Reference advances on its own prediction so line errors never poison it.
          h_d = {h_q[4:0], exp_bit};
          if (din != exp_bit) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (miss_inc == LOSS_FULL) begin
              state_d    = ST_SEARCH;
              fill_cnt_d = 3'd0;
              ok_cnt_d   = 4'd0;
              miss_cnt_d = 2'd0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            miss_cnt_d = 2'd0;
          end
        end
      end

      default: begin
        state_d    = ST_SEARCH;
        fill_cnt_d = 3'd0;
        ok_cnt_d   = 4'd0;
        miss_cnt_d = 2'd0;
      end
    endcase

    if (clr_cnt) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEARCH;
      h_q        <= 6'd0;
      fill_cnt_q <= 3'd0;
      ok_cnt_q   <= 4'd0;
      miss_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      fill_cnt_q <= fill_cnt_d;
      ok_cnt_q   <= ok_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign state   = state_q;

endmodule

// File: tb/tb_lfsr6_prbs_checker.sv
// Bench for lfsr6_prbs_checker: a queue-based reference checker predicts every output each cycle,
// and directed scenarios pin lock, error, loss, saturation, clear, gap and reset behaviour.
module tb_lfsr6_prbs_checker;

  logic       clk = 1'b0;
  logic       rst, en, din, clr_cnt;
  logic       locked, err;
  logic [7:0] err_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  lfsr6_prbs_checker dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din     (din),
    .clr_cnt (clr_cnt),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .state   (state)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int err_seen = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference generator: one full period of the sequence started from seed 0,0,0,1,1,1.
  int gen[0:62];
  int idx = 0;

  // Reference checker: hist holds the last six reference bits, hist[0] the oldest.
  int mode;  // 0 searching, 1 verifying, 2 locked
  int m_fill, m_ok, m_miss, m_cnt, m_exp, zsum;
  bit m_err;
  int hist[$];

  always @(posedge clk) begin
    if (rst) begin
      mode = 0; m_fill = 0; m_ok = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0;
      hist = '{0, 0, 0, 0, 0, 0};
    end else begin
      m_err = 1'b0;
      if (en) begin
        m_exp = hist[0] ^ hist[1];
        if (mode == 2) hist.push_back(m_exp);
        else           hist.push_back(int'(din));
        void'(hist.pop_front());
        if (mode == 0) begin
          m_fill++;
          if (m_fill == 6) begin
            m_fill = 0;
            zsum = 0;
            foreach (hist[i]) zsum += hist[i];
            if (zsum != 0) begin mode = 1; m_ok = 0; end
          end
        end else if (mode == 1) begin
          if (int'(din) == m_exp) begin
            m_ok++;
            if (m_ok == 8) begin mode = 2; m_ok = 0; m_miss = 0; end
          end else begin
            mode = 0; m_fill = 0; m_ok = 0;
          end
        end else begin
          if (int'(din) != m_exp) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_miss++;
            if (m_miss == 3) begin mode = 0; m_fill = 0; m_ok = 0; m_miss = 0; end
          end else begin
            m_miss = 0;
          end
        end
      end
      if (clr_cnt) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", int'(state), mode);
      chk("locked", int'(locked), int'(mode == 2));
      chk("err", int'(err), int'(m_err));
      chk("err_cnt", int'(err_cnt), m_cnt);
      if (err) err_seen++;
    end
  end

  task automatic drive(input logic r, input logic e, input logic d, input logic c);
    @(negedge clk);
    rst = r; en = e; din = d; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit flip, input bit c);
    drive(1'b0, 1'b1, logic'(gen[idx % 63] != 0) ^ flip, c);
    idx++;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idx = 0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lock_up();
    repeat (14) send(1'b0, 1'b0);
  endtask

  initial begin
    int e0;
    int v;
    rst = 1'b1; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;

    gen[0] = 0; gen[1] = 0; gen[2] = 0; gen[3] = 1; gen[4] = 1; gen[5] = 1;
    for (int i = 6; i < 63; i++) gen[i] = gen[i-6] ^ gen[i-5];
    v = 0;
    for (int i = 6; i < 14; i++) v = v * 2 + gen[i];
    chk("seq_pin_bits7to14", v, 37);          // 0,0,1,0,0,1,0,1
    chk("seq_pin_wrap", gen[57] ^ gen[58], 0); // bit 64 equals bit 1 of the seed

    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Reset state and clean lock; lock must land exactly on the 14th valid bit.
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    repeat (13) send(1'b0, 1'b0);
    chk("lock_13_locked", int'(locked), 0);
    chk("lock_13_state", int'(state), 1);
    send(1'b0, 1'b0);
    chk("lock_14_locked", int'(locked), 1);
    chk("lock_14_state", int'(state), 2);
    chk("lock_14_err_cnt", int'(err_cnt), 0);

    // Single error while locked.
    repeat (3) send(1'b0, 1'b0);
    idle();
    e0 = err_seen;
    send(1'b1, 1'b0);
    repeat (5) send(1'b0, 1'b0);
    idle();
    chk("single_err_pulses", err_seen - e0, 1);
    chk("single_err_cnt", int'(err_cnt), 1);
    chk("single_err_locked", int'(locked), 1);

    // Loss of lock after three consecutive errors.
    do_reset();
    lock_up();
    repeat (3) send(1'b0, 1'b0);
    idle();
    e0 = err_seen;
    repeat (3) send(1'b1, 1'b0);
    chk("loss_err_3rd", int'(err), 1);
    chk("loss_locked", int'(locked), 0);
    chk("loss_state", int'(state), 0);
    chk("loss_err_cnt", int'(err_cnt), 3);
    idle();
    chk("loss_err_pulses", err_seen - e0, 3);

    // All-zero line never leaves search.
    do_reset();
    e0 = err_seen;
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("zero_state", int'(state), 0);
    chk("zero_locked", int'(locked), 0);
    chk("zero_err_pulses", err_seen - e0, 0);

    // Saturation, then clear colliding with a counted error.
    do_reset();
    lock_up();
    e0 = err_seen;
    repeat (300) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
    end
    idle();
    chk("sat_err_cnt", int'(err_cnt), 255);
    chk("sat_locked", int'(locked), 1);
    chk("sat_err_pulses", err_seen - e0, 300);
    send(1'b1, 1'b1);
    chk("clr_err", int'(err), 1);
    chk("clr_err_cnt", int'(err_cnt), 0);

    // Lock through en gaps, then reset (with en and a flipped bit) while locked.
    do_reset();
    repeat (14) begin
      send(1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("gap_locked", int'(locked), 1);
    chk("gap_state", int'(state), 2);
    chk("gap_err_cnt", int'(err_cnt), 0);
    send(1'b1, 1'b0);
    idle();
    chk("gap_one_err_cnt", int'(err_cnt), 1);
    drive(1'b1, 1'b1, logic'(gen[idx % 63] == 0), 1'b0);
    idx = 0;
    chk("rst_lock_locked", int'(locked), 0);
    chk("rst_lock_err_cnt", int'(err_cnt), 0);
    chk("rst_lock_err", int'(err), 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
